uart_rx_buffer: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_buffer_if.sv | 23 ++
 rtl/uart_byte_fifo.sv | 52 +++++
 rtl/uart_rx_buffer.sv | 97 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: byte type, capture FSM states, default depth,
// and a saturating counter helper used by the optional statistics.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int DEFAULT_RX_DEPTH = 8;

  typedef logic [UART_DATA_BITS-1:0] byte_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_PEND
  } cap_state_e;

  // Clear takes priority over the old value, but an increment in the same cycle still lands.
  function automatic byte_t satIncClr(input byte_t cur, input logic inc, input logic clr);
    byte_t result;
    result = cur;
    if (clr) begin
      result = inc ? byte_t'(1) : byte_t'(0);
    end else if (inc && (cur != '1)) begin
      result = cur + byte_t'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-facing inputs plus the host-facing valid/ready byte stream of the rx buffer.
// slave = buffer side, master = receiver/host side.
interface uart_rx_buffer_if;
  import uart_pkg::*;

  byte_t rxData;
  logic  rxDone;
  logic  rxErr;
  byte_t outData;
  logic  outValid;
  logic  outReady;

  modport master (
    output rxData, rxDone, rxErr, outReady,
    input  outData, outValid
  );

  modport slave (
    input  rxData, rxDone, rxErr, outReady,
    output outData, outValid
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Generic show-ahead synchronous byte FIFO with wrap-bit pointers. A push while full
// is accepted only if a pop frees a slot in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int Depth = DEFAULT_RX_DEPTH
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   push,
  input  byte_t                  pushData,
  output logic                   full,
  input  logic                   pop,
  output byte_t                  popData,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int AW = $clog2(Depth);

  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  byte_t       mem [Depth];
  logic        popEff;
  logic        pushEff;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign count   = wrPtr - rdPtr;
  assign popEff  = pop && !empty;
  assign pushEff = push && (!full || popEff);

  // Storage is deliberately left out of reset; the empty gate below hides stale contents.
  always_ff @(posedge clk) begin
    if (pushEff) begin
      mem[wrPtr[AW-1:0]] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushEff) wrPtr <= wrPtr + 1'b1;
      if (popEff)  rdPtr <= rdPtr + 1'b1;
    end
  end

  assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures rxData the cycle after rxDone into a show-ahead FIFO,
// with sticky overrun/frameErr flags. Define UART_RX_BUFFER_STATS_EN for drop/err counters.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int Depth           = DEFAULT_RX_DEPTH,
  parameter int AlmostFullLevel = 6
) (
  input  logic                   clk,
  input  logic                   nReset,
  uart_rx_buffer_if.slave        bus,
  output logic [$clog2(Depth):0] count,
  output logic                   almostFull,
  output logic                   overrun,
  output logic                   frameErr,
  input  logic                   clearFlags
`ifdef UART_RX_BUFFER_STATS_EN
  ,
  output logic [7:0]             dropCount,
  output logic [7:0]             errCount
`endif
);

  localparam int CW = $clog2(Depth) + 1;
  localparam logic [CW-1:0] AfLevel = CW'(AlmostFullLevel);

  cap_state_e capState;
  cap_state_e capStateNext;
  logic       pushReq;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       dropEvent;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) capState <= CAP_IDLE;
    else         capState <= capStateNext;
  end

  // A repeated rxDone while pending simply re-arms the capture.
  always_comb begin
    capStateNext = CAP_IDLE;
    case (capState)
      CAP_IDLE: if (bus.rxDone) capStateNext = CAP_PEND;
      CAP_PEND: if (bus.rxDone) capStateNext = CAP_PEND;
      default:  capStateNext = CAP_IDLE;
    endcase
  end

  always_comb begin
    pushReq = 1'b0;
    if (capState == CAP_PEND) pushReq = 1'b1;
  end

  uart_byte_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk     (clk),
    .nReset  (nReset),
    .push    (pushReq),
    .pushData(bus.rxData),
    .full    (fifoFull),
    .pop     (bus.outReady),
    .popData (bus.outData),
    .empty   (fifoEmpty),
    .count   (count)
  );

  assign bus.outValid = !fifoEmpty;
  assign almostFull   = (count >= AfLevel);
  // Full implies non-empty, so outReady alone decides whether a slot frees up.
  assign dropEvent    = pushReq && fifoFull && !bus.outReady;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (dropEvent)       overrun <= 1'b1;
      else if (clearFlags) overrun <= 1'b0;
      if (bus.rxErr)       frameErr <= 1'b1;
      else if (clearFlags) frameErr <= 1'b0;
    end
  end

`ifdef UART_RX_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dropCount <= '0;
      errCount  <= '0;
    end else begin
      dropCount <= satIncClr(dropCount, dropEvent, clearFlags);
      errCount  <= satIncClr(errCount, bus.rxErr, clearFlags);
    end
  end
`endif

endmodule
